// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports plus the data-memory side of the
// arbiter. The arbiter connects through the slave modport; the
// environment that drives requests and models the memory uses master.
interface dmem_arbiter_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
);
    logic              req0,   req1;
    logic              we0,    we1;
    logic [AWIDTH-1:0] addr0,  addr1;
    logic [DWIDTH-1:0] wdata0, wdata1;
    logic [2:0]        size0,  size1;
    logic              ack0,   ack1;
    logic              err0,   err1;
    logic [DWIDTH-1:0] rdata0, rdata1;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic [2:0]        mem_size;
    logic [DWIDTH-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, size0, size1,
        input  mem_rdata,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output mem_we, mem_addr, mem_wdata, mem_size,
        output busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, size0, size1,
        output mem_rdata,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  mem_we, mem_addr, mem_wdata, mem_size,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory.
// Each transaction runs IDLE -> ACCESS -> DONE. The memory is expected to
// place store bytes and to align/extend load data itself from mem_addr and
// mem_size; the arbiter only registers what it returns during ACCESS.
module dmem_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, next_state;
    logic              ptr;
    logic              gnt;
    logic              gnt_sel;
    logic              any_req;
    logic              illegal;
    logic              we_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        size_q;
    logic [DWIDTH-1:0] rdata_q;

    // Pick the winner: a lone requester always wins, a tie goes to ptr.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        gnt_sel = (bus.req0 && bus.req1) ? ptr : bus.req1;
    end

    // Alignment/size check on the latched request.
    always_comb begin
        illegal = 1'b0;
        case (size_q[1:0])
            2'b11:   illegal = 1'b1;
            2'b01:   illegal = addr_q[0];
            2'b10:   illegal = (addr_q[1:0] != 2'b00);
            default: illegal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ACCESS;
            ACCESS:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Grant bookkeeping, request capture and load-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= 1'b0;
            gnt     <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rdata_q <= '0;
        end else if (state == IDLE && any_req) begin
            gnt     <= gnt_sel;
            ptr     <= ~gnt_sel;
            we_q    <= gnt_sel ? bus.we1    : bus.we0;
            addr_q  <= gnt_sel ? bus.addr1  : bus.addr0;
            wdata_q <= gnt_sel ? bus.wdata1 : bus.wdata0;
            size_q  <= gnt_sel ? bus.size1  : bus.size0;
        end else if (state == ACCESS) begin
            rdata_q <= bus.mem_rdata;
        end
    end

    // Outputs; everything is forced quiet while rst is high so an aborted
    // store never reaches the memory and no stale ack escapes.
    always_comb begin
        bus.ack0      = 1'b0;
        bus.ack1      = 1'b0;
        bus.err0      = 1'b0;
        bus.err1      = 1'b0;
        bus.rdata0    = '0;
        bus.rdata1    = '0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = '0;
        bus.busy      = 1'b0;
        if (!rst) begin
            bus.busy      = (state != IDLE);
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
            bus.mem_size  = size_q;
            bus.mem_we    = (state == ACCESS) && we_q && !illegal;
            if (state == DONE) begin
                if (gnt) begin
                    bus.ack1   = 1'b1;
                    bus.err1   = illegal;
                    bus.rdata1 = (illegal || we_q) ? '0 : rdata_q;
                end else begin
                    bus.ack0   = 1'b1;
                    bus.err0   = illegal;
                    bus.rdata0 = (illegal || we_q) ? '0 : rdata_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed,
// little-endian memory that performs lane placement and load extension.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;
    int   writeCount;
    logic [31:0] mem [8];

    dmem_arbiter_if #(.AWIDTH(5), .DWIDTH(32)) bus ();

    dmem_arbiter #(.AWIDTH(5), .DWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory store path with byte lanes selected by size and address.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            writeCount <= writeCount + 1;
            case (bus.mem_size[1:0])
                2'b00: case (bus.mem_addr[1:0])
                    2'd0: mem[bus.mem_addr[4:2]][7:0]   <= bus.mem_wdata[7:0];
                    2'd1: mem[bus.mem_addr[4:2]][15:8]  <= bus.mem_wdata[7:0];
                    2'd2: mem[bus.mem_addr[4:2]][23:16] <= bus.mem_wdata[7:0];
                    default: mem[bus.mem_addr[4:2]][31:24] <= bus.mem_wdata[7:0];
                endcase
                2'b01: if (bus.mem_addr[1]) mem[bus.mem_addr[4:2]][31:16] <= bus.mem_wdata[15:0];
                       else                 mem[bus.mem_addr[4:2]][15:0]  <= bus.mem_wdata[15:0];
                default: mem[bus.mem_addr[4:2]] <= bus.mem_wdata;
            endcase
        end
    end

    // Memory asynchronous load path with alignment and extension.
    always_comb begin
        logic [31:0] word;
        logic [31:0] shifted;
        word    = mem[bus.mem_addr[4:2]];
        shifted = word >> {bus.mem_addr[1:0], 3'b000};
        case (bus.mem_size[1:0])
            2'b00:   bus.mem_rdata = bus.mem_size[2] ? {{24{shifted[7]}}, shifted[7:0]}
                                                     : {24'h0, shifted[7:0]};
            2'b01:   bus.mem_rdata = bus.mem_size[2] ? {{16{shifted[15]}}, shifted[15:0]}
                                                     : {16'h0, shifted[15:0]};
            default: bus.mem_rdata = word;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] size);
        if (port == 0) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.size0 = size;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.size1 = size;
        end
    endtask

    // One single-port transaction: returns after the DONE cycle is visible.
    task automatic runToDone(input int port, input logic we, input logic [4:0] addr,
                             input logic [31:0] wdata, input logic [2:0] size);
        applyStimulus(port, 1'b1, we, addr, wdata, size);
        tick();
        applyStimulus(port, 1'b0, we, addr, wdata, size);
        tick();
    endtask

    // Directed sequence.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        writeCount    = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        applyStimulus(0, 1'b0, 1'b0, 5'd0, 32'h0, 3'b000);
        applyStimulus(1, 1'b0, 1'b0, 5'd0, 32'h0, 3'b000);
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_busy",  {31'h0, bus.busy},   32'h0);
        checkOutput("rst_ack0",  {31'h0, bus.ack0},   32'h0);
        checkOutput("rst_memwe", {31'h0, bus.mem_we}, 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_busy",  {31'h0, bus.busy}, 32'h0);
        checkOutput("post_rst_addr",  {27'h0, bus.mem_addr}, 32'h0);
        checkOutput("post_rst_rdata", bus.rdata0 | bus.rdata1, 32'h0);

        // Word store from port 0; addr0 moves to 12 during ACCESS.
        applyStimulus(0, 1'b1, 1'b1, 5'd4, 32'hDEADBEEF, 3'b010);
        tick();
        checkOutput("st_access_busy", {31'h0, bus.busy},   32'h1);
        checkOutput("st_access_we",   {31'h0, bus.mem_we}, 32'h1);
        checkOutput("st_access_ack",  {31'h0, bus.ack0},   32'h0);
        applyStimulus(0, 1'b0, 1'b1, 5'd12, 32'h11111111, 3'b010);
        tick();
        checkOutput("st_done_ack0",  {31'h0, bus.ack0},   32'h1);
        checkOutput("st_done_err0",  {31'h0, bus.err0},   32'h0);
        checkOutput("st_done_rdata", bus.rdata0,          32'h0);
        checkOutput("st_done_we",    {31'h0, bus.mem_we}, 32'h0);
        checkOutput("st_done_ack1",  {31'h0, bus.ack1},   32'h0);
        checkOutput("st_done_addr",  {27'h0, bus.mem_addr}, 32'd4);
        tick();
        checkOutput("st_idle_ack0",  {31'h0, bus.ack0}, 32'h0);
        checkOutput("st_idle_busy",  {31'h0, bus.busy}, 32'h0);
        checkOutput("st_writes",     writeCount,        32'd1);
        checkOutput("st_mem4",       mem[1],            32'hDEADBEEF);
        checkOutput("st_mem12",      mem[3],            32'h0);

        // Loads from port 1 with various sizes.
        runToDone(1, 1'b0, 5'd4, 32'h0, 3'b100);
        checkOutput("lb_sext_ack1",  {31'h0, bus.ack1}, 32'h1);
        checkOutput("lb_sext_data",  bus.rdata1,        32'hFFFFFFEF);
        checkOutput("lb_sext_ack0",  {31'h0, bus.ack0}, 32'h0);
        checkOutput("lb_sext_rd0",   bus.rdata0,        32'h0);
        tick();
        runToDone(1, 1'b0, 5'd4, 32'h0, 3'b000);
        checkOutput("lb_zext_data",  bus.rdata1,        32'h000000EF);
        tick();
        runToDone(1, 1'b0, 5'd6, 32'h0, 3'b101);
        checkOutput("lh_sext_data",  bus.rdata1,        32'hFFFFDEAD);
        tick();
        runToDone(0, 1'b0, 5'd4, 32'h0, 3'b010);
        checkOutput("lw_data",       bus.rdata0,        32'hDEADBEEF);
        tick();

        // Illegal accesses: misaligned word load, size 11 store.
        runToDone(0, 1'b0, 5'd6, 32'h0, 3'b010);
        checkOutput("mis_ack0",  {31'h0, bus.ack0}, 32'h1);
        checkOutput("mis_err0",  {31'h0, bus.err0}, 32'h1);
        checkOutput("mis_rdata", bus.rdata0,        32'h0);
        tick();
        applyStimulus(1, 1'b1, 1'b1, 5'd0, 32'h12345678, 3'b011);
        tick();
        checkOutput("ill_access_we", {31'h0, bus.mem_we}, 32'h0);
        applyStimulus(1, 1'b0, 1'b1, 5'd0, 32'h12345678, 3'b011);
        tick();
        checkOutput("ill_ack1",  {31'h0, bus.ack1}, 32'h1);
        checkOutput("ill_err1",  {31'h0, bus.err1}, 32'h1);
        checkOutput("ill_rdata", bus.rdata1,        32'h0);
        tick();
        checkOutput("ill_mem0",   mem[0],     32'h0);
        checkOutput("ill_writes", writeCount, 32'd1);

        // Round robin from reset with both ports held high.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 5'd4, 32'h0, 3'b010);
        applyStimulus(1, 1'b1, 1'b0, 5'd4, 32'h0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("rr_access_busy", {31'h0, bus.busy}, 32'h1);
            tick();
            checkOutput("rr_grant", {30'h0, bus.ack1, bus.ack0}, (i % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("rr_rdata", bus.rdata0 | bus.rdata1, 32'hDEADBEEF);
            tick();
        end
        applyStimulus(0, 1'b0, 1'b0, 5'd4, 32'h0, 3'b010);
        applyStimulus(1, 1'b0, 1'b0, 5'd4, 32'h0, 3'b010);
        tick();
        checkOutput("rr_quiet_busy", {31'h0, bus.busy}, 32'h0);

        // Reset during ACCESS of a store to 8 aborts it and clears the pointer.
        applyStimulus(0, 1'b1, 1'b1, 5'd8, 32'hCAFEF00D, 3'b010);
        tick();
        applyStimulus(0, 1'b0, 1'b1, 5'd8, 32'hCAFEF00D, 3'b010);
        rst = 1'b1;
        #1;
        checkOutput("abort_we_in_rst", {31'h0, bus.mem_we}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("abort_busy", {31'h0, bus.busy}, 32'h0);
        tick();
        checkOutput("abort_ack0", {31'h0, bus.ack0}, 32'h0);
        checkOutput("abort_mem8", mem[2],            32'h0);
        applyStimulus(0, 1'b1, 1'b0, 5'd4, 32'h0, 3'b010);
        applyStimulus(1, 1'b1, 1'b0, 5'd4, 32'h0, 3'b010);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 5'd4, 32'h0, 3'b010);
        applyStimulus(1, 1'b0, 1'b0, 5'd4, 32'h0, 3'b010);
        tick();
        checkOutput("abort_ptr_grant", {30'h0, bus.ack1, bus.ack0}, 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
